// File: rtl/mips_cpu_data_ram_if.sv
// mips_cpu_data_ram_if: CPU data-port bus between the CPU (master) and the data RAM (slave).
interface mips_cpu_data_ram_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output data_address, data_read, data_write, data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_address, data_read, data_write, data_writedata,
        output data_readdata
    );
endinterface

// File: rtl/mips_cpu_data_ram.sv
// mips_cpu_data_ram: self-clearing word RAM on the CPU data port with a sticky address-error flag; DATA_RAM_STATS_EN adds saturating read/write counters.
module mips_cpu_data_ram #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    mips_cpu_data_ram_if.slave bus,
    output logic               cpu_clk_enable,
    output logic               addr_error
`ifdef DATA_RAM_STATS_EN
    ,
    output logic [31:0]        read_count,
    output logic [31:0]        write_count
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           mem [DEPTH];
    logic                  ready, in_range, valid, rd_ok, wr_ok, bad;

    // Address decode: 33-bit upper-bound compare so a window ending at 4 GiB cannot wrap.
    always_comb begin
        ready = state == READY;
        in_range = (bus.data_address >= BASE_ADDR) &&
                   ({1'b0, bus.data_address} < {1'b0, BASE_ADDR} + (33'(DEPTH) << 2));
        valid = (bus.data_address[1:0] == 2'b00) && in_range;
        idx = ADDR_WIDTH'((bus.data_address - BASE_ADDR) >> 2);
        rd_ok = ready && bus.data_read && valid;
        wr_ok = ready && bus.data_write && valid;
        bad = ready && (bus.data_read || bus.data_write) && !valid;
        bus.data_readdata = rd_ok ? mem[idx] : 32'h0;
        cpu_clk_enable = ready;
    end

    // Next state: leave INIT once the last word is being cleared.
    always_comb begin
        state_next = state;
        if (state == INIT && &clear_ptr)
            state_next = READY;
    end

    // State register, clear pointer and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            clear_ptr  <= '0;
            addr_error <= 1'b0;
        end else begin
            state      <= state_next;
            clear_ptr  <= (state == INIT) ? clear_ptr + ADDR_WIDTH'(1) : clear_ptr;
            addr_error <= addr_error | bad;
        end
    end

    // Storage: init sequence owns the write port until READY; reset gating comes via state.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[clear_ptr] <= INIT_VALUE;
        else if (wr_ok)
            mem[idx] <= bus.data_writedata;
    end

`ifdef DATA_RAM_STATS_EN
    // Saturating counters of accepted reads and writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (rd_ok && read_count != '1)
                read_count <= read_count + 32'd1;
            if (wr_ok && write_count != '1)
                write_count <= write_count + 32'd1;
        end
    end
`endif
endmodule

// File: doc/mips_cpu_data_ram.md
# mips_cpu_data_ram

Word-organised data RAM acting as the responder on the CPU's data port. It answers `data_address`/`data_read`/`data_write`/`data_writedata` with a combinational read and a single-cycle write. After every reset it clears its own contents with a counter-driven init sequence and holds the CPU clock enable low until the sequence finishes. It also flags illegal accesses with a sticky error bit.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1000_0000: byte address of word 0; must be word-aligned.
- `ADDR_WIDTH`, default 10: word-index width; `DEPTH` = 2^ADDR_WIDTH words.
- `INIT_VALUE`, default 32'h0000_0000: value written to every word during init.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `data_address`, input, 32: byte address from the CPU.
- `data_read`, input, 1: read strobe.
- `data_write`, input, 1: write strobe.
- `data_writedata`, input, 32: write data.
- `data_readdata`, output, 32: read data, combinational.
- `cpu_clk_enable`, output, 1: high only in READY; drives the CPU `clk_enable`.
- `addr_error`, output, 1: sticky illegal-access flag.
- `read_count`, output, 32: present only with `DATA_RAM_STATS_EN`.
- `write_count`, output, 32: present only with `DATA_RAM_STATS_EN`.

## Operation
- FSM states: INIT and READY. `reset` forces INIT, sets `clear_ptr` to 0, and clears `addr_error` and the counters.
- INIT, per cycle:
  - `mem[clear_ptr] <= INIT_VALUE`.
  - `clear_ptr` increments.
  - When `clear_ptr == DEPTH-1`, that last word is written and the next state is READY.
- In INIT: CPU strobes are ignored, no error is flagged, and `data_readdata = 0`.
- In READY, an access is *valid* when both hold:
  - `data_address[1:0] == 0`.
  - `BASE_ADDR <= data_address < BASE_ADDR + 4*DEPTH`, compared as unsigned 32-bit values with no wrap-around.
- Word index: `(data_address - BASE_ADDR) >> 2`, truncated to `ADDR_WIDTH` bits.
- Read: `data_readdata = mem[idx]` when `data_read` is high and the access is valid; otherwise 32'h0.
- Write: `mem[idx] <= data_writedata` at the rising edge when `data_write` is high and the access is valid.
- Read and write strobes in the same cycle: both act. The read returns the pre-write value, and the new value is visible from the next cycle.
- Invalid access (either strobe high, access not valid): the write is dropped, `data_readdata = 0`, and `addr_error` is set at the edge. `addr_error` stays set until `reset`.
- Strobes low: no state change, `data_readdata = 0`.

## Timing
- Reset values:
  - `cpu_clk_enable` = 0.
  - `addr_error` = 0.
  - `data_readdata` = 0.
  - `read_count` = `write_count` = 0.
  - FSM state = INIT, `clear_ptr` = 0.
- Init length: exactly `DEPTH` rising edges after `reset` falls. `cpu_clk_enable` rises after the DEPTH-th edge, taken combinationally from the state register.
- Read latency: 0 cycles (combinational from address and strobe).
- Write latency: 1 edge.
- `addr_error` rises 1 edge after the illegal access.
- Reset asserted mid-init or mid-operation takes effect immediately and restarts init from word 0. An in-flight write at that edge is lost.

## Configuration
- Macro `DATA_RAM_STATS_EN`.
- Defined:
  - `read_count` increments on every edge with a valid read.
  - `write_count` increments on every edge with a valid write; a simultaneous read and write increments both.
  - Invalid accesses and INIT cycles are not counted.
  - Counters saturate at 32'hFFFF_FFFF.
- Undefined: both counter ports and their logic are absent.

## Test plan
- Reset, then release: `cpu_clk_enable` stays 0 for exactly 1024 edges and is 1 after them. Every word then reads 32'h0.
- Write 32'hDEAD_BEEF to address 32'h1000_0010, then read the same address on the next cycle: 32'hDEAD_BEEF returned. The word at 32'h1000_0014 still reads 0.
- Same cycle, read and write 32'h1234_5678 to address 32'h1000_0020 holding 32'hAAAA_AAAA: `data_readdata` = 32'hAAAA_AAAA that cycle and 32'h1234_5678 the next.
- Write to 32'h1000_0002 (misaligned) and to 32'h1000_1000 (out of range):
  - Both writes dropped and reads return 0.
  - `addr_error` = 1 one edge after the first illegal access, and stays 1.
  - With `DATA_RAM_STATS_EN`, counts unchanged.
- Assert `reset` at init edge 500 and after a READY write: `addr_error` = 0, counters = 0, full 1024-edge init repeats, and the previously written word reads 0.
- With `DATA_RAM_STATS_EN`: 3 valid reads and 2 valid writes, one of each in the same cycle, give `read_count` = 3 and `write_count` = 2.
